controller_multiciclo: RTL and testbench
========================================

// Module: controller_multiciclo
// PURPOSE
// - Multi-cycle RV32I-subset control unit; sits directly upstream of the datapath.
// - Fetches instructions over a req/ready handshake and holds the PC.
// - Decodes each instruction into RS1/RS2/RD/IMM/ALUControl/ALUSrc/MemtoReg/RegWrite/link/pclink for the datapath.
// - Resolves branches and jumps from the datapath flags (Zero/Neg/Carry) and PCReg.
// PARAMETERS
// NBITS       8   datapath/PC width; PC is a byte address, wraps mod 2**NBITS
// NREGS       32  register count; register index width = $clog2(NREGS)
// WIDTH_ALUF  4   ALUControl width
// PORTS
// clock       in   1             clock
// reset       in   1             synchronous, active-high reset
// imem_req    out  1             instruction fetch request
// imem_addr   out  NBITS         fetch address (= pc)
// imem_ready  in   1             fetch data valid this cycle
// imem_rdata  in   32            instruction word
// RS1,RS2,RD  out  $clog2(NREGS) register indices (instr[19:15], [24:20], [11:7]; upper bits dropped)
// IMM         out  NBITS         sign-extended immediate, truncated to NBITS
// ALUControl  out  WIDTH_ALUF    ALU operation code
// ALUSrc      out  1             1: SrcB = IMM; 0: SrcB = reg[RS2]
// MemtoReg    out  1             1: write-back from ReadData
// RegWrite    out  1             register-file write enable
// MemWrite    out  1             data-memory write strobe
// link        out  1             write pclink to RD
// pclink      out  NBITS         pc + 4
// Zero,Neg,Carry in 1            datapath compare flags (SrcA - SrcB)
// PCReg       in   NBITS         reg[RS1] value, used as the JALR base
// illegal     out  1             one-cycle pulse: unsupported opcode
// BEHAVIOUR
// - Reset is synchronous and active-high on clock, and applies mid-instruction.
//   - Reset state: pc=0, instruction register=0, state=FETCH.
//   - All outputs are 0 while reset is high (imem_addr=0, imem_req=0).
//   - imem_req rises in the first cycle after reset falls.
// - Supported set: ADDI, ADD, SUB, AND, OR, LW, SW, BEQ, BNE, BLT, BGE, JAL, JALR.
// - FSM states: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
// - FETCH: imem_req=1, imem_addr=pc, held until imem_ready.
//   - On imem_ready: latch imem_rdata into the instruction register; go to DECODE.
//   - imem_req drops the cycle after the ready cycle.
// - DECODE: register fields and IMM become valid from the instruction register and stay stable until the next FETCH completes.
// - EXECUTE: ALUControl is driven per opcode.
//   - Codes: ADD=0 for ADDI/ADD/LW/SW/JAL/JALR, SUB=1 for SUB and branches, AND=2, OR=3.
//   - ALUSrc=1 for ADDI/LW/SW/JALR.
//   - Branch: taken if BEQ&Zero | BNE&!Zero | BLT&Neg | BGE&!Neg.
//     - Taken: pc <= pc+IMM. Not taken: pc <= pc+4. Then go to FETCH.
//   - JAL: pc <= pc+IMM. JALR: pc <= (PCReg+IMM) & ~1. Then go to WRITEBACK.
//   - LW/SW: go to MEMORY. R-type/ADDI: go to WRITEBACK.
//   - Illegal opcode: illegal=1 for one cycle, pc <= pc+4, no writes, go to FETCH.
// - MEMORY: SW asserts MemWrite=1 for exactly one cycle, pc <= pc+4, then FETCH. LW goes to WRITEBACK.
// - WRITEBACK: RegWrite=1 for exactly one cycle.
//   - MemtoReg=1 for LW. link=1 for JAL/JALR.
//   - pc <= pc+4, except JAL/JALR, whose pc was already updated. Then FETCH.
// - pclink = pc_of_instruction + 4, captured in DECODE so it survives the JAL/JALR pc update.
// - RD = 0: RegWrite is still asserted; x0 is protected in the datapath.
// - Arithmetic: all pc math is modulo 2**NBITS (0xFC + 4 = 0x00).
//   - Immediates are sign-extended per format (I/S/B/J), then truncated to NBITS.
// - Latency with imem_ready in the first cycle:
//   - ALU/JAL/JALR: 4 cycles. LW: 5. SW: 4. Branch: 3.
//   - Each imem_ready wait cycle adds 1.
// - Control outputs RegWrite, MemWrite, link and MemtoReg are 0 in every state not listed above.
// STRUCTURE
// - Shared package riscv_pkg:
//   - opcode constants (OP_IMM=7'h13, OP=7'h33, LOAD=7'h03, STORE=7'h23, BRANCH=7'h63, JAL=7'h6F, JALR=7'h67);
//   - funct3 codes;
//   - ALU code enum (ALU_ADD..ALU_OR);
//   - state_t enum.
// - One sub-module imm_gen (combinational):
//   - inputs: instruction word; output: NBITS sign-extended immediate;
//   - selects the format from the opcode.
// TESTING
// - Reset mid-EXECUTE of a branch:
//   - next cycle pc=0, state FETCH, all control outputs 0;
//   - imem_req=1 the cycle after reset falls.
// - ADDI x5,x0,7 (0x00700293), ready immediately:
//   - RS1=0, RD=5, IMM=7, ALUSrc=1, ALUControl=0;
//   - RegWrite high exactly 1 cycle in cycle 4; pc 0 -> 4.
// - Fetch stall: imem_ready low for 3 cycles:
//   - imem_req and imem_addr held stable;
//   - instruction latched only on the ready cycle; latency 4+3.
// - BEQ at pc=0x10, offset -8, Zero=1:
//   - pc=0x08, no RegWrite/MemWrite.
//   - Same instruction with Zero=0: pc=0x14.
// - JAL x1,+12 at pc=0xF8, NBITS=8:
//   - pc=0x04 (wrap), link=1, pclink=0xFC, RegWrite 1 cycle.
//   - JALR with PCReg=0x21, IMM=0: pc=0x20.
// - SW then LW:
//   - SW: MemWrite exactly 1 cycle, RegWrite never high.
//   - LW: MemtoReg=1 with RegWrite in cycle 5.
//   - Opcode 0x7F: illegal pulse, pc+4.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset controller:
// opcode and funct3 encodings, ALU operation codes and FSM states.
package riscv_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;

  // funct3 codes (instr[14:12])
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;

  // ALU operation codes seen by the datapath
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3
  } alu_op_t;

  // Controller FSM states
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the I/S/B/J format from the opcode,
// sign-extends to 32 bits and truncates to the datapath width.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic [31:0]      instr,
  output logic [NBITS-1:0] imm
);

  logic [31:0] imm_full;

  // Assemble the sign-extended immediate for the instruction's format
  always_comb begin
    imm_full = 32'h0000_0000;
    case (instr[6:0])
      OP_IMM, LOAD, JALR: imm_full = {{20{instr[31]}}, instr[31:20]};
      STORE:              imm_full = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      BRANCH:             imm_full = {{19{instr[31]}}, instr[31], instr[7],
                                      instr[30:25], instr[11:8], 1'b0};
      JAL:                imm_full = {{11{instr[31]}}, instr[31], instr[19:12],
                                      instr[20], instr[30:21], 1'b0};
      default:            imm_full = 32'h0000_0000;
    endcase
  end

  assign imm = NBITS'(imm_full);

endmodule

// File: rtl/controller_multiciclo.sv
// Multi-cycle control unit for an RV32I subset. Owns the PC and the
// instruction register, fetches over a req/ready handshake, decodes fields
// for the datapath and resolves branches/jumps from the datapath flags.
module controller_multiciclo
  import riscv_pkg::*;
#(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      imem_req,
  output logic [NBITS-1:0]          imem_addr,
  input  logic                      imem_ready,
  input  logic [31:0]               imem_rdata,
  output logic [$clog2(NREGS)-1:0]  RS1,
  output logic [$clog2(NREGS)-1:0]  RS2,
  output logic [$clog2(NREGS)-1:0]  RD,
  output logic [NBITS-1:0]          IMM,
  output logic [WIDTH_ALUF-1:0]     ALUControl,
  output logic                      ALUSrc,
  output logic                      MemtoReg,
  output logic                      RegWrite,
  output logic                      MemWrite,
  output logic                      link,
  output logic [NBITS-1:0]          pclink,
  input  logic                      Zero,
  input  logic                      Neg,
  input  logic                      Carry,
  input  logic [NBITS-1:0]          PCReg,
  output logic                      illegal
);

  localparam int RBITS = $clog2(NREGS);
  localparam logic [NBITS-1:0] PC_STEP = NBITS'(4);

  state_t           state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [NBITS-1:0] pclink_q, pclink_d;

  logic [NBITS-1:0] imm_s;
  logic [6:0]       opcode_s;
  logic [2:0]       funct3_s;
  logic             is_alui_s, is_reg_s, is_lw_s, is_sw_s;
  logic             is_br_s, is_jal_s, is_jalr_s, is_legal_s;
  logic             alu_src_s, br_taken_s;
  alu_op_t          alu_op_s;

  logic             req_s, reg_write_s, mem_write_s, link_s, mem_to_reg_s, illegal_s;

  // Carry is part of the datapath interface but no supported instruction needs it
  logic unused_s;
  assign unused_s = ^{Carry, instr_q[31], instr_q[29:25]};

  imm_gen #(.NBITS(NBITS)) u_imm_gen (
    .instr (instr_q),
    .imm   (imm_s)
  );

  // Decode the latched instruction into class flags, ALU op and branch outcome
  always_comb begin
    opcode_s   = instr_q[6:0];
    funct3_s   = instr_q[14:12];
    is_alui_s  = (opcode_s == OP_IMM);
    is_reg_s   = (opcode_s == OP);
    is_lw_s    = (opcode_s == LOAD);
    is_sw_s    = (opcode_s == STORE);
    is_br_s    = (opcode_s == BRANCH);
    is_jal_s   = (opcode_s == JAL);
    is_jalr_s  = (opcode_s == JALR);
    is_legal_s = is_alui_s | is_reg_s | is_lw_s | is_sw_s | is_br_s | is_jal_s | is_jalr_s;
    alu_src_s  = is_alui_s | is_lw_s | is_sw_s | is_jalr_s;

    alu_op_s = ALU_ADD;
    if (is_br_s) begin
      alu_op_s = ALU_SUB;
    end else if (is_reg_s) begin
      case (funct3_s)
        F3_ADD_SUB: alu_op_s = instr_q[30] ? ALU_SUB : ALU_ADD;
        F3_AND:     alu_op_s = ALU_AND;
        F3_OR:      alu_op_s = ALU_OR;
        default:    alu_op_s = ALU_ADD;
      endcase
    end else begin
      alu_op_s = ALU_ADD;
    end

    br_taken_s = 1'b0;
    case (funct3_s)
      F3_BEQ:  br_taken_s = Zero;
      F3_BNE:  br_taken_s = ~Zero;
      F3_BLT:  br_taken_s = Neg;
      F3_BGE:  br_taken_s = ~Neg;
      default: br_taken_s = 1'b0;
    endcase
  end

  // Next-state, PC update and per-state control strobes
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pclink_d     = pclink_q;
    req_s        = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    link_s       = 1'b0;
    mem_to_reg_s = 1'b0;
    illegal_s    = 1'b0;

    case (state_q)
      FETCH: begin
        req_s = 1'b1;
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        // pclink captured here so it survives the JAL/JALR pc update
        pclink_d = pc_q + PC_STEP;
        state_d  = EXECUTE;
      end
      EXECUTE: begin
        if (is_br_s) begin
          pc_d    = br_taken_s ? (pc_q + imm_s) : (pc_q + PC_STEP);
          state_d = FETCH;
        end else if (is_jal_s) begin
          pc_d    = pc_q + imm_s;
          state_d = WRITEBACK;
        end else if (is_jalr_s) begin
          pc_d    = (PCReg + imm_s) & ~NBITS'(1);
          state_d = WRITEBACK;
        end else if (is_lw_s | is_sw_s) begin
          state_d = MEMORY;
        end else if (is_alui_s | is_reg_s) begin
          state_d = WRITEBACK;
        end else begin
          illegal_s = 1'b1;
          pc_d      = pc_q + PC_STEP;
          state_d   = FETCH;
        end
      end
      MEMORY: begin
        if (is_sw_s) begin
          mem_write_s = 1'b1;
          pc_d        = pc_q + PC_STEP;
          state_d     = FETCH;
        end else begin
          state_d = WRITEBACK;
        end
      end
      WRITEBACK: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = is_lw_s;
        link_s       = is_jal_s | is_jalr_s;
        if (is_jal_s | is_jalr_s) begin
          pc_d = pc_q;
        end else begin
          pc_d = pc_q + PC_STEP;
        end
        state_d = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State, PC, instruction and link registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= {NBITS{1'b0}};
      instr_q  <= 32'h0000_0000;
      pclink_q <= {NBITS{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pclink_q <= pclink_d;
    end
  end

  // Drive the datapath; everything is held at zero while reset is high
  always_comb begin
    if (reset) begin
      imem_req   = 1'b0;
      imem_addr  = {NBITS{1'b0}};
      RS1        = {RBITS{1'b0}};
      RS2        = {RBITS{1'b0}};
      RD         = {RBITS{1'b0}};
      IMM        = {NBITS{1'b0}};
      ALUControl = {WIDTH_ALUF{1'b0}};
      ALUSrc     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      link       = 1'b0;
      pclink     = {NBITS{1'b0}};
      illegal    = 1'b0;
    end else begin
      imem_req   = req_s;
      imem_addr  = pc_q;
      RS1        = instr_q[15 +: RBITS];
      RS2        = instr_q[20 +: RBITS];
      RD         = instr_q[7 +: RBITS];
      IMM        = imm_s;
      ALUControl = WIDTH_ALUF'(alu_op_s);
      ALUSrc     = alu_src_s;
      MemtoReg   = mem_to_reg_s;
      RegWrite   = reg_write_s;
      MemWrite   = mem_write_s;
      link       = link_s;
      pclink     = pclink_q;
      illegal    = illegal_s;
    end
  end

endmodule

// File: tb/tb_controller_multiciclo.sv
// Directed testbench for controller_multiciclo (NBITS=8, NREGS=32).
module tb_controller_multiciclo;

  logic        clock, reset;
  logic        imem_req, imem_ready;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [4:0]  rs1, rs2, rd;
  logic [7:0]  imm, pclink, pc_reg;
  logic [3:0]  alu_ctl;
  logic        alu_src, mem_to_reg, reg_write, mem_write, link, illegal;
  logic        zero, neg, carry;

  int total, bad;
  int lat, rw_cnt, rw_cycle, mw_cnt, link_cnt, ill_cnt, m2r_cnt, m2r_at_rw;

  controller_multiciclo dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .RS1        (rs1),
    .RS2        (rs2),
    .RD         (rd),
    .IMM        (imm),
    .ALUControl (alu_ctl),
    .ALUSrc     (alu_src),
    .MemtoReg   (mem_to_reg),
    .RegWrite   (reg_write),
    .MemWrite   (mem_write),
    .link       (link),
    .pclink     (pclink),
    .Zero       (zero),
    .Neg        (neg),
    .Carry      (carry),
    .PCReg      (pc_reg),
    .illegal    (illegal)
  );

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Run one instruction from its FETCH cycle back to the next FETCH.
  // Must be entered shortly after a negedge with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ins, input int delay,
                           input logic z, input logic n, input logic [7:0] pcr);
    logic       left, done, fired;
    logic [7:0] pc0;
    logic [4:0] rd0;
    zero = z; neg = n; carry = 1'b0; pc_reg = pcr;
    lat = 0; rw_cnt = 0; rw_cycle = 0; mw_cnt = 0; link_cnt = 0;
    ill_cnt = 0; m2r_cnt = 0; m2r_at_rw = 0;
    left = 1'b0; done = 1'b0; fired = 1'b0;
    pc0 = imem_addr; rd0 = rd;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (!fired && c > delay) begin
        imem_ready = 1'b1; imem_rdata = ins; fired = 1'b1;
      end else begin
        imem_ready = 1'b0; imem_rdata = 32'h0000_007F;
      end
      #1;
      if (left && imem_req) begin
        lat  = c - 1;
        done = 1'b1;
      end else begin
        if (c <= delay) begin
          check_eq("stall_req", {31'd0, imem_req}, 32'd1);
          check_eq("stall_addr", {24'd0, imem_addr}, {24'd0, pc0});
          check_eq("stall_rd", {27'd0, rd}, {27'd0, rd0});
        end
        if (!imem_req) left = 1'b1;
        if (reg_write) begin
          rw_cnt++; rw_cycle = c;
          if (mem_to_reg) m2r_at_rw++;
        end
        if (mem_write)  mw_cnt++;
        if (link)       link_cnt++;
        if (illegal)    ill_cnt++;
        if (mem_to_reg) m2r_cnt++;
        @(negedge clock); #1;
      end
    end
    imem_ready = 1'b0;
    if (!done) check_eq("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0000_0000;
    zero = 1'b0; neg = 1'b0; carry = 1'b0; pc_reg = 8'h00;

    // Reset state
    @(negedge clock); @(negedge clock); #1;
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_addr", {24'd0, imem_addr}, 32'h00);
    check_eq("rst_ctl", {26'd0, reg_write, mem_write, link, mem_to_reg, illegal, alu_src}, 32'd0);
    reset = 1'b0;
    @(negedge clock); #1;
    check_eq("rel_req", {31'd0, imem_req}, 32'd1);
    check_eq("rel_addr", {24'd0, imem_addr}, 32'h00);

    // ADDI x5,x0,7 at pc 0
    run_instr(32'h0070_0293, 0, 1'b0, 1'b0, 8'h00);
    check_eq("addi_rs1", {27'd0, rs1}, 32'd0);
    check_eq("addi_rd", {27'd0, rd}, 32'd5);
    check_eq("addi_imm", {24'd0, imm}, 32'd7);
    check_eq("addi_alusrc", {31'd0, alu_src}, 32'd1);
    check_eq("addi_aluctl", {28'd0, alu_ctl}, 32'd0);
    check_eq("addi_rw_cnt", rw_cnt, 32'd1);
    check_eq("addi_rw_cycle", rw_cycle, 32'd4);
    check_eq("addi_lat", lat, 32'd4);
    check_eq("addi_pc", {24'd0, imem_addr}, 32'h04);
    check_eq("addi_pclink", {24'd0, pclink}, 32'h04);

    // ADD x6,x5,x5 at pc 4 with three stall cycles
    run_instr(32'h0052_8333, 3, 1'b0, 1'b0, 8'h00);
    check_eq("add_lat", lat, 32'd7);
    check_eq("add_rw_cycle", rw_cycle, 32'd7);
    check_eq("add_rd", {27'd0, rd}, 32'd6);
    check_eq("add_rs2", {27'd0, rs2}, 32'd5);
    check_eq("add_alusrc", {31'd0, alu_src}, 32'd0);
    check_eq("add_pc", {24'd0, imem_addr}, 32'h08);

    // SUB x7,x6,x5 at pc 8
    run_instr(32'h4053_03B3, 0, 1'b0, 1'b0, 8'h00);
    check_eq("sub_aluctl", {28'd0, alu_ctl}, 32'd1);
    check_eq("sub_pc", {24'd0, imem_addr}, 32'h0C);

    // Illegal opcode 0x7F at pc 0xC
    run_instr(32'h0000_007F, 0, 1'b0, 1'b0, 8'h00);
    check_eq("ill_cnt", ill_cnt, 32'd1);
    check_eq("ill_writes", rw_cnt + mw_cnt, 32'd0);
    check_eq("ill_lat", lat, 32'd3);
    check_eq("ill_pc", {24'd0, imem_addr}, 32'h10);

    // BEQ -8 at 0x10, taken
    run_instr(32'hFE00_0CE3, 0, 1'b1, 1'b0, 8'h00);
    check_eq("beq_t_imm", {24'd0, imm}, 32'hF8);
    check_eq("beq_t_aluctl", {28'd0, alu_ctl}, 32'd1);
    check_eq("beq_t_lat", lat, 32'd3);
    check_eq("beq_t_writes", rw_cnt + mw_cnt, 32'd0);
    check_eq("beq_t_pc", {24'd0, imem_addr}, 32'h08);

    // Two ADDIs to return to 0x10
    for (int k = 0; k < 2; k++) run_instr(32'h0070_0293, 0, 1'b0, 1'b0, 8'h00);
    check_eq("addi2_pc", {24'd0, imem_addr}, 32'h10);

    // BEQ not taken, then BLT taken, BGE not taken, BNE not taken
    run_instr(32'hFE00_0CE3, 0, 1'b0, 1'b0, 8'h00);
    check_eq("beq_nt_pc", {24'd0, imem_addr}, 32'h14);
    run_instr(32'hFE00_4CE3, 0, 1'b0, 1'b1, 8'h00);
    check_eq("blt_t_pc", {24'd0, imem_addr}, 32'h0C);
    run_instr(32'hFE00_5CE3, 0, 1'b0, 1'b1, 8'h00);
    check_eq("bge_nt_pc", {24'd0, imem_addr}, 32'h10);
    run_instr(32'hFE00_1CE3, 0, 1'b1, 1'b0, 8'h00);
    check_eq("bne_nt_pc", {24'd0, imem_addr}, 32'h14);

    // Reset during EXECUTE of a branch at 0x14
    zero = 1'b1; imem_rdata = 32'hFE00_0CE3; imem_ready = 1'b1;
    @(negedge clock); #1;
    imem_ready = 1'b0;
    @(negedge clock); #1;
    reset = 1'b1; #1;
    check_eq("mrst_req_hi", {31'd0, imem_req}, 32'd0);
    check_eq("mrst_addr_hi", {24'd0, imem_addr}, 32'h00);
    @(negedge clock); #1;
    check_eq("mrst_ctl", {26'd0, reg_write, mem_write, link, mem_to_reg, illegal, alu_src}, 32'd0);
    check_eq("mrst_imm", {24'd0, imm}, 32'h00);
    reset = 1'b0;
    @(negedge clock); #1;
    check_eq("mrst_req", {31'd0, imem_req}, 32'd1);
    check_eq("mrst_pc", {24'd0, imem_addr}, 32'h00);

    // JALR x1,0(x2) with PCReg=0x21 at pc 0
    run_instr(32'h0001_00E7, 0, 1'b0, 1'b0, 8'h21);
    check_eq("jalr_pc", {24'd0, imem_addr}, 32'h20);
    check_eq("jalr_link", link_cnt, 32'd1);
    check_eq("jalr_pclink", {24'd0, pclink}, 32'h04);
    check_eq("jalr_lat", lat, 32'd4);

    // JALR x0,0(x2) with PCReg=0xF9 lands at 0xF8
    run_instr(32'h0001_0067, 0, 1'b0, 1'b0, 8'hF9);
    check_eq("jalr2_pc", {24'd0, imem_addr}, 32'hF8);

    // JAL x1,+12 at 0xF8 wraps to 0x04
    run_instr(32'h00C0_00EF, 0, 1'b0, 1'b0, 8'h00);
    check_eq("jal_pc", {24'd0, imem_addr}, 32'h04);
    check_eq("jal_imm", {24'd0, imm}, 32'h0C);
    check_eq("jal_pclink", {24'd0, pclink}, 32'hFC);
    check_eq("jal_link", link_cnt, 32'd1);
    check_eq("jal_rw_cnt", rw_cnt, 32'd1);
    check_eq("jal_rw_cycle", rw_cycle, 32'd4);

    // SW x5,8(x0) at pc 4
    run_instr(32'h0050_2423, 0, 1'b0, 1'b0, 8'h00);
    check_eq("sw_mw_cnt", mw_cnt, 32'd1);
    check_eq("sw_rw_cnt", rw_cnt, 32'd0);
    check_eq("sw_imm", {24'd0, imm}, 32'h08);
    check_eq("sw_lat", lat, 32'd4);
    check_eq("sw_pc", {24'd0, imem_addr}, 32'h08);

    // LW x6,8(x0) at pc 8
    run_instr(32'h0080_2303, 0, 1'b0, 1'b0, 8'h00);
    check_eq("lw_rw_cnt", rw_cnt, 32'd1);
    check_eq("lw_rw_cycle", rw_cycle, 32'd5);
    check_eq("lw_m2r", m2r_at_rw, 32'd1);
    check_eq("lw_m2r_cnt", m2r_cnt, 32'd1);
    check_eq("lw_mw_cnt", mw_cnt, 32'd0);
    check_eq("lw_lat", lat, 32'd5);
    check_eq("lw_pc", {24'd0, imem_addr}, 32'h0C);

    // AND and OR
    run_instr(32'h0053_73B3, 0, 1'b0, 1'b0, 8'h00);
    check_eq("and_aluctl", {28'd0, alu_ctl}, 32'd2);
    run_instr(32'h0053_63B3, 0, 1'b0, 1'b0, 8'h00);
    check_eq("or_aluctl", {28'd0, alu_ctl}, 32'd3);
    check_eq("or_pc", {24'd0, imem_addr}, 32'h14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
